// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, alu and response signals for alu_share_arbiter.
// slave = arbiter side, master = surrounding CPU/alu/consumer side.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [2:0]            req0_op;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [2:0]            req1_op;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;

  logic [DATA_WIDTH-1:0] alu_A;
  logic [DATA_WIDTH-1:0] alu_B;
  logic [2:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_overflow;
  logic                  alu_carryout;
  logic                  alu_zero;

  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_id;
  logic [DATA_WIDTH-1:0] resp_result;
  logic                  resp_overflow;
  logic                  resp_carryout;
  logic                  resp_zero;
  logic                  busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_A, alu_B, alu_op,
    input  alu_result, alu_overflow, alu_carryout, alu_zero,
    output resp_valid, resp_id, resp_result, resp_overflow, resp_carryout, resp_zero,
    input  resp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_A, alu_B, alu_op,
    output alu_result, alu_overflow, alu_carryout, alu_zero,
    input  resp_valid, resp_id, resp_result, resp_overflow, resp_carryout, resp_zero,
    output resp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational alu between two requesters: arbitrate, execute one cycle, hold response.
// Define ALU_ARB_RR_EN for round-robin arbitration; default build is fixed priority (req0 wins).
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_share_arbiter_if.slave   bus
);

  localparam int unsigned OP_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]       op_q, op_d;
  logic                  id_q, id_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_id_q, resp_id_d;
  logic [DATA_WIDTH-1:0] resp_result_q, resp_result_d;
  logic                  resp_ovf_q, resp_ovf_d;
  logic                  resp_cout_q, resp_cout_d;
  logic                  resp_zero_q, resp_zero_d;
  logic                  busy_q, busy_d;
  logic                  any_valid_c;
  logic                  grant_c;

  assign any_valid_c = bus.req0_valid | bus.req1_valid;

`ifdef ALU_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // Tie goes to whoever did not win the last transfer; a lone requester always wins.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant_c = ~last_grant_q;
    else                                  grant_c = ~bus.req0_valid;
  end
`else
  assign grant_c = ~bus.req0_valid;
`endif

  // Next-state, datapath capture and combinational ready.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    id_d          = id_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_ovf_d    = resp_ovf_q;
    resp_cout_d   = resp_cout_q;
    resp_zero_d   = resp_zero_q;
    busy_d        = busy_q;
`ifdef ALU_ARB_RR_EN
    last_grant_d  = last_grant_q;
`endif
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_valid_c) begin
          bus.req0_ready = ~grant_c;
          bus.req1_ready = grant_c;
          id_d    = grant_c;
          op_d    = grant_c ? bus.req1_op : bus.req0_op;
          a_d     = grant_c ? bus.req1_a  : bus.req0_a;
          b_d     = grant_c ? bus.req1_b  : bus.req0_b;
          busy_d  = 1'b1;
          state_d = S_EXEC;
`ifdef ALU_ARB_RR_EN
          last_grant_d = grant_c;
`endif
        end
      end
      S_EXEC: begin
        resp_valid_d  = 1'b1;
        resp_id_d     = id_q;
        resp_result_d = bus.alu_result;
        resp_ovf_d    = bus.alu_overflow;
        resp_cout_d   = bus.alu_carryout;
        resp_zero_d   = bus.alu_zero;
        state_d       = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= 3'b000;
      id_q          <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_ovf_q    <= 1'b0;
      resp_cout_q   <= 1'b0;
      resp_zero_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant_q  <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      id_q          <= id_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_ovf_q    <= resp_ovf_d;
      resp_cout_q   <= resp_cout_d;
      resp_zero_q   <= resp_zero_d;
      busy_q        <= busy_d;
`ifdef ALU_ARB_RR_EN
      last_grant_q  <= last_grant_d;
`endif
    end
  end

  assign bus.alu_A         = a_q;
  assign bus.alu_B         = b_q;
  assign bus.alu_op        = op_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_id       = resp_id_q;
  assign bus.resp_result   = resp_result_q;
  assign bus.resp_overflow = resp_ovf_q;
  assign bus.resp_carryout = resp_cout_q;
  assign bus.resp_zero     = resp_zero_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a randomized scoreboard run.
// Honours ALU_ARB_RR_EN the same way the design does.
module tb_alu_share_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_share_arbiter_if #(.DATA_WIDTH(32)) bus ();

  alu_share_arbiter #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference alu: returns {overflow, carryout, zero, result}.
  function automatic logic [34:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        ovf;
    logic        cout;
    s = '0; r = '0; ovf = 1'b0; cout = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cout = s[32];
        ovf = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b011: r = {31'd0, (a < b)};
      3'b100: r = a ^ b;
      3'b101: r = ~(a | b);
      3'b110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; cout = s[32];
        ovf = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: r = {31'd0, ($signed(a) < $signed(b))};
    endcase
    return {ovf, cout, (r == 32'd0), r};
  endfunction

  assign {bus.alu_overflow, bus.alu_carryout, bus.alu_zero, bus.alu_result} =
         alu_ref(bus.alu_op, bus.alu_A, bus.alu_B);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = 3'b000; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 3'b000; bus.req1_a = '0; bus.req1_b = '0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Present one request until accepted; returns just after the transfer edge.
  task automatic send(input bit id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (id) begin bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; end
    else    begin bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; end
    for (int i = 0; i < 50; i++) begin
      #1;
      if ((id && bus.req1_ready) || (!id && bus.req0_ready)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
  endtask

  // Wait (bounded) at negedges until a response is presented.
  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (bus.resp_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1; idle_inputs();
    @(negedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {bus.req0_ready, bus.req1_ready}); end
    checks++; if ({bus.alu_A, bus.alu_B, bus.alu_op} !== 67'd0) begin errors++; $display("FAIL reset_alu_regs got %h/%h/%b exp 0", bus.alu_A, bus.alu_B, bus.alu_op); end
    checks++; if ({bus.resp_id, bus.resp_result, bus.resp_overflow, bus.resp_carryout, bus.resp_zero} !== 36'd0) begin errors++; $display("FAIL reset_resp_regs got %h exp 0", bus.resp_result); end
    rst = 1'b0;
    // Reset while the op is in EXEC.
    send(1'b0, 3'b010, 32'd1, 32'd2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midexec_accept got timeout exp transfer"); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midexec_busy_before got %b exp 1", bus.busy); end
    rst = 1'b1; #1;
    checks++; if ({bus.busy, bus.resp_valid} !== 2'b00) begin errors++; $display("FAIL midexec_reset got busy/valid %b exp 00", {bus.busy, bus.resp_valid}); end
    checks++; if (bus.alu_A !== 32'd0) begin errors++; $display("FAIL midexec_alu_A got %h exp 0", bus.alu_A); end
    @(negedge clk); rst = 1'b0; bus.resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      checks++; if ({bus.resp_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL midexec_no_resp got valid/busy %b exp 00", {bus.resp_valid, bus.busy}); end
    end
  endtask

  task automatic test_add();
    bit ok;
    bus.resp_ready = 1'b1;
    send(1'b0, 3'b010, 32'd5, 32'd7, ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_accept got timeout exp transfer"); end
    @(negedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL add_exec_valid got %b exp 0", bus.resp_valid); end
    checks++; if ({bus.alu_A, bus.alu_B, bus.alu_op} !== {32'd5, 32'd7, 3'b010}) begin errors++; $display("FAIL add_alu_drive got %h/%h/%b exp 5/7/010", bus.alu_A, bus.alu_B, bus.alu_op); end
    @(negedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL add_latency got %b exp 1", bus.resp_valid); end
    checks++; if ({bus.resp_id, bus.resp_result, bus.resp_zero} !== {1'b0, 32'd12, 1'b0}) begin errors++; $display("FAIL add_resp got id %b res %h z %b exp 0/c/0", bus.resp_id, bus.resp_result, bus.resp_zero); end
    @(negedge clk); #1;
    checks++; if ({bus.resp_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL add_handshake got %b exp 00", {bus.resp_valid, bus.busy}); end
  endtask

  task automatic test_sub_sltu();
    bit ok;
    bit ok2;
    bus.resp_ready = 1'b1;
    send(1'b1, 3'b110, 32'h8000_0000, 32'd1, ok);
    wait_resp(ok2);
    checks++; if (!(ok && ok2)) begin errors++; $display("FAIL sub_handshake got timeout exp response"); end
    checks++; if ({bus.resp_id, bus.resp_result, bus.resp_overflow} !== {1'b1, 32'h7FFF_FFFF, 1'b1}) begin errors++; $display("FAIL sub_resp got id %b res %h ovf %b exp 1/7fffffff/1", bus.resp_id, bus.resp_result, bus.resp_overflow); end
    send(1'b1, 3'b011, 32'd1, 32'hFFFF_FFFF, ok);
    wait_resp(ok2);
    checks++; if (!(ok && ok2)) begin errors++; $display("FAIL sltu_handshake got timeout exp response"); end
    checks++; if ({bus.resp_id, bus.resp_result} !== {1'b1, 32'd1}) begin errors++; $display("FAIL sltu_resp got id %b res %h exp 1/1", bus.resp_id, bus.resp_result); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit ok2;
    @(negedge clk); bus.resp_ready = 1'b0;
    send(1'b0, 3'b010, 32'd3, 32'hFFFF_FFFD, ok);
    wait_resp(ok2);
    checks++; if (!(ok && ok2)) begin errors++; $display("FAIL bp_handshake got timeout exp response"); end
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if ({bus.resp_valid, bus.resp_result, bus.resp_zero, bus.resp_carryout} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL bp_hold got v %b res %h z %b c %b exp 1/0/1/1", bus.resp_valid, bus.resp_result, bus.resp_zero, bus.resp_carryout); end
      checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready got %b exp 00", {bus.req0_ready, bus.req1_ready}); end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.resp_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", bus.resp_valid); end
  endtask

  task automatic test_arbitration();
    bit grants[$];
    bit exp_g;
    idle_inputs();
    do_reset();
    bus.resp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = 3'b001; bus.req0_a = 32'h10; bus.req0_b = 32'h01;
    bus.req1_valid = 1'b1; bus.req1_op = 3'b100; bus.req1_a = 32'hFF; bus.req1_b = 32'h0F;
    for (int i = 0; i < 40 && grants.size() < 4; i++) begin
      @(negedge clk); #1;
      if (bus.req0_ready === 1'b1) grants.push_back(1'b0);
      if (bus.req1_ready === 1'b1) grants.push_back(1'b1);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    checks++; if (grants.size() != 4) begin errors++; $display("FAIL arb_count got %0d exp 4", grants.size()); end
    foreach (grants[i]) begin
`ifdef ALU_ARB_RR_EN
      exp_g = (i % 2) == 1;
`else
      exp_g = 1'b0;
`endif
      checks++; if (grants[i] !== exp_g) begin errors++; $display("FAIL arb_grant%0d got %b exp %b", i, grants[i], exp_g); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_valid_drop();
    bit ok;
    bit ok2;
    idle_inputs();
    send(1'b1, 3'b000, 32'hF0, 32'h3C, ok);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); bus.req0_valid = 1'b1; bus.req0_op = 3'b010; bus.req0_a = 32'd9; #1;
      checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL drop_ready got %b exp 0", bus.req0_ready); end
    end
    bus.req0_valid = 1'b0;
    wait_resp(ok2);
    checks++; if (!(ok && ok2)) begin errors++; $display("FAIL drop_handshake got timeout exp response"); end
    checks++; if ({bus.resp_id, bus.resp_result} !== {1'b1, 32'h30}) begin errors++; $display("FAIL drop_resp got id %b res %h exp 1/30", bus.resp_id, bus.resp_result); end
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      checks++; if ({bus.resp_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL drop_no_extra got valid/busy %b exp 00", {bus.resp_valid, bus.busy}); end
    end
  endtask

  // Scoreboard: one op in flight, response due two cycles after transfer, held until taken.
  task automatic test_random();
    bit          pending;
    int          age;
    bit          last_g;
    bit          v0, v1, g0, g1, gid, exp_rv;
    bit          exp_id;
    logic [31:0] exp_a, exp_b;
    logic [2:0]  exp_op;
    logic [34:0] exp_res;
    idle_inputs();
    do_reset();
    pending = 1'b0; age = 0; last_g = 1'b1;
    exp_id = 1'b0; exp_a = '0; exp_b = '0; exp_op = '0; exp_res = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      v0 = ($urandom % 3) != 0; v1 = ($urandom % 2) != 0;
      bus.req0_valid = v0; bus.req1_valid = v1;
      bus.req0_op = 3'($urandom); bus.req1_op = 3'($urandom);
      bus.req0_a = $urandom; bus.req1_a = $urandom;
      bus.req0_b = (($urandom % 4) == 0) ? bus.req0_a : $urandom;
      bus.req1_b = (($urandom % 4) == 0) ? bus.req1_a : $urandom;
      bus.resp_ready = ($urandom % 3) != 0;
      #1;
      if (pending) age++;
      exp_rv = pending && (age >= 2);
      checks++; if ({bus.resp_valid, bus.busy} !== {exp_rv, pending}) begin errors++; $display("FAIL rnd_status cyc %0d got valid/busy %b exp %b", cyc, {bus.resp_valid, bus.busy}, {exp_rv, pending}); end
      if (pending) begin
        checks++; if ({bus.alu_A, bus.alu_B, bus.alu_op} !== {exp_a, exp_b, exp_op}) begin errors++; $display("FAIL rnd_alu_drive cyc %0d got %h/%h/%b exp %h/%h/%b", cyc, bus.alu_A, bus.alu_B, bus.alu_op, exp_a, exp_b, exp_op); end
      end
      if (exp_rv) begin
        checks++; if ({bus.resp_id, bus.resp_overflow, bus.resp_carryout, bus.resp_zero, bus.resp_result} !== {exp_id, exp_res}) begin errors++; $display("FAIL rnd_resp cyc %0d got id %b flags %b%b%b res %h exp id %b all %h", cyc, bus.resp_id, bus.resp_overflow, bus.resp_carryout, bus.resp_zero, bus.resp_result, exp_id, exp_res); end
      end
      g0 = 1'b0; g1 = 1'b0;
      if (!pending && (v0 || v1)) begin
`ifdef ALU_ARB_RR_EN
        gid = (v0 && v1) ? !last_g : !v0;
`else
        gid = !v0;
`endif
        g0 = !gid; g1 = gid;
      end
      checks++; if ({bus.req0_ready, bus.req1_ready} !== {g0, g1}) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, {bus.req0_ready, bus.req1_ready}, {g0, g1}); end
      if (exp_rv && bus.resp_ready) begin
        pending = 1'b0;
      end else if (g0 || g1) begin
        exp_id  = g1;
        exp_a   = g1 ? bus.req1_a  : bus.req0_a;
        exp_b   = g1 ? bus.req1_b  : bus.req0_b;
        exp_op  = g1 ? bus.req1_op : bus.req0_op;
        exp_res = alu_ref(exp_op, exp_a, exp_b);
        last_g  = g1;
        pending = 1'b1; age = 0;
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_add();
    test_sub_sltu();
    test_backpressure();
    test_arbitration();
    test_valid_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
